// File: rtl/scic_pkg.sv
// Shared encodings for the SCIC accumulator CPU: opcodes, FSM states, memory-op decode.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package scic_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SHL  = 4'h2,
        OP_SHR  = 4'h3,
        OP_LDI  = 4'h4,
        OP_LD   = 4'h5,
        OP_OR   = 4'h6,
        OP_ST   = 4'h7,
        OP_JMP  = 4'h8,
        OP_AND  = 4'h9,
        OP_SUB  = 4'hA,
        OP_JZ   = 4'hB,
        OP_JN   = 4'hC,
        OP_XOR  = 4'hD,
        OP_JC   = 4'hE,
        OP_HALT = 4'hF
    } op_e;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MEM   = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    localparam int OP_W = 4;

    // Ops that need a second memory transaction at the operand address.
    function automatic logic is_mem_op(input op_e op);
        case (op)
            OP_ADD, OP_SHL, OP_SHR, OP_LD, OP_OR,
            OP_ST, OP_AND, OP_SUB, OP_XOR: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/scic_alu.sv
// scic_alu: combinational accumulator datapath (result and carry/borrow out).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the caller decides when result is committed.
module scic_alu
    import scic_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [OP_W-1:0]   opcode,
    input  logic [DATA_W-1:0] ac,
    input  logic [DATA_W-1:0] m,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [DATA_W:0] sum;

    always_comb begin
        result = ac;
        carry  = 1'b0;
        sum    = '0;
        case (op_e'(opcode))
            OP_ADD: begin
                sum    = {1'b0, ac} + {1'b0, m};
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
            end
            OP_SUB: begin
                // Top bit of the widened difference is the borrow (m > ac unsigned).
                sum    = {1'b0, ac} - {1'b0, m};
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
            end
            // Full-width shift amount: anything >= DATA_W shifts everything out.
            OP_SHL:  result = ac << m;
            OP_SHR:  result = ac >> m;
            OP_LD:   result = m;
            OP_OR:   result = ac | m;
            OP_AND:  result = ac & m;
            OP_XOR:  result = ac ^ m;
            default: result = ac;
        endcase
    end

endmodule

// File: rtl/scic_cpu_p.sv
// scic_cpu_p: parametrised SCIC accumulator CPU (FETCH/EXEC/MEM/HALT FSM, req/ack memory port).
// Latency: register op 2 cycles, memory op 3 cycles, +1 per cycle mem_ack is withheld.
// Backpressure: req/we/addr/wdata held until mem_ack; SCIC_CARRY_EN adds a carry flag and JC.
module scic_cpu_p
    import scic_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] ac,
    output logic              halted
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] ac_q, ac_d;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    op_e               opcode;
    logic [ADDR_W-1:0] operand;

    assign opcode  = op_e'(ir_q[DATA_W-1 -: OP_W]);
    assign operand = ir_q[ADDR_W-1:0];

    scic_alu #(.DATA_W(DATA_W)) u_alu (
        .opcode (ir_q[DATA_W-1 -: OP_W]),
        .ac     (ac_q),
        .m      (mem_rdata),
        .result (alu_result),
        .carry  (alu_carry)
    );

`ifdef SCIC_CARRY_EN
    logic c_q, c_d;
`else
    logic unused_carry;
    assign unused_carry = alu_carry;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        ac_d    = ac_q;
`ifdef SCIC_CARRY_EN
        c_d     = c_q;
`endif
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = pc_q;
        case (state_q)
            ST_FETCH: begin
                // Reset gates the request so an abandoned transaction is never re-driven.
                mem_req = !reset;
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (is_mem_op(opcode)) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_FETCH;
                    case (opcode)
                        OP_LDI:  ac_d = DATA_W'(operand);
                        OP_JMP:  pc_d = operand;
                        OP_JZ:   if (ac_q == '0) pc_d = operand;
                        OP_JN:   if (ac_q[DATA_W-1]) pc_d = operand;
`ifdef SCIC_CARRY_EN
                        OP_JC:   if (c_q) pc_d = operand;
`endif
                        OP_HALT: state_d = ST_HALT;
                        default: ;
                    endcase
                end
            end
            ST_MEM: begin
                mem_req  = !reset;
                mem_we   = !reset && (opcode == OP_ST);
                mem_addr = operand;
                if (mem_ack) begin
                    if (opcode != OP_ST) ac_d = alu_result;
`ifdef SCIC_CARRY_EN
                    if (opcode == OP_ADD || opcode == OP_SUB) c_d = alu_carry;
`endif
                    state_d = ST_FETCH;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            ac_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ac_q    <= ac_d;
        end
    end

`ifdef SCIC_CARRY_EN
    always_ff @(posedge clock) begin
        if (reset) c_q <= 1'b0;
        else       c_q <= c_d;
    end
`endif

    assign mem_wdata = ac_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign ac        = ac_q;
    assign halted    = (state_q == ST_HALT);

endmodule
